// File: rtl/hazard_unit.sv
// Tuse/Tnew hazard controller for the 5-stage MIPS pipeline: tracks E/M/W
// destinations and result-ready times, and drives stall and forwarding selects.
module hazard_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic [3:0]  type_d,
  output logic        stall,
  output logic [1:0]  fwd_rs_d,
  output logic [1:0]  fwd_rt_d,
  output logic [1:0]  fwd_rs_e,
  output logic [1:0]  fwd_rt_e,
  output logic        fwd_rt_m
);

  localparam int unsigned RW = 5;
  localparam int unsigned TW = 2;

  localparam logic [3:0] T_R   = 4'd1;
  localparam logic [3:0] T_IMM = 4'd2;
  localparam logic [3:0] T_BEQ = 4'd3;
  localparam logic [3:0] T_LW  = 4'd4;
  localparam logic [3:0] T_JR  = 4'd5;
  localparam logic [3:0] T_JAL = 4'd6;
  localparam logic [3:0] T_SW  = 4'd7;

  logic [RW-1:0] rs_d, rt_d, rd_d;
  logic          unused_bits;

  assign rs_d        = instr_d[25:21];
  assign rt_d        = instr_d[20:16];
  assign rd_d        = instr_d[15:11];
  assign unused_bits = ^{instr_d[31:26], instr_d[10:0]};

  // ID decode: a source field of 0 means "not read", a dest of 0 means "no write"
  logic [RW-1:0] src_rs_d, src_rt_d, dest_d;
  logic [TW-1:0] tuse_rs_d, tuse_rt_d, tnew_d;
  logic          sw_d;

  always_comb begin
    src_rs_d  = '0;
    src_rt_d  = '0;
    dest_d    = '0;
    tuse_rs_d = '0;
    tuse_rt_d = '0;
    tnew_d    = '0;
    sw_d      = 1'b0;
    case (type_d)
      T_R: begin
        src_rs_d = rs_d; tuse_rs_d = TW'(1);
        src_rt_d = rt_d; tuse_rt_d = TW'(1);
        dest_d   = rd_d; tnew_d    = TW'(1);
      end
      T_IMM: begin
        src_rs_d = rs_d; tuse_rs_d = TW'(1);
        dest_d   = rt_d; tnew_d    = TW'(1);
      end
      T_BEQ: begin
        src_rs_d = rs_d;
        src_rt_d = rt_d;
      end
      T_LW: begin
        src_rs_d = rs_d; tuse_rs_d = TW'(1);
        dest_d   = rt_d; tnew_d    = TW'(2);
      end
      T_JR: begin
        src_rs_d = rs_d;
      end
      T_JAL: begin
        dest_d = RW'(31); tnew_d = TW'(1);
      end
      T_SW: begin
        src_rs_d = rs_d; tuse_rs_d = TW'(1);
        src_rt_d = rt_d; tuse_rt_d = TW'(2);
        sw_d     = 1'b1;
      end
      default: ;
    endcase
    // $0 is never a real destination
    if (dest_d == '0) tnew_d = '0;
  end

  // Pipeline state behind ID
  logic [RW-1:0] dest_e, src_rs_e, src_rt_e, dest_m, sw_rt_m, dest_w;
  logic [TW-1:0] tnew_e, tnew_m;
  logic          sw_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_e   <= '0;
      src_rs_e <= '0;
      src_rt_e <= '0;
      tnew_e   <= '0;
      sw_e     <= 1'b0;
      dest_m   <= '0;
      tnew_m   <= '0;
      sw_rt_m  <= '0;
      dest_w   <= '0;
    end else begin
      if (stall) begin
        dest_e   <= '0;
        src_rs_e <= '0;
        src_rt_e <= '0;
        tnew_e   <= '0;
        sw_e     <= 1'b0;
      end else begin
        dest_e   <= dest_d;
        src_rs_e <= src_rs_d;
        src_rt_e <= src_rt_d;
        tnew_e   <= tnew_d;
        sw_e     <= sw_d;
      end
      dest_m  <= dest_e;
      tnew_m  <= (tnew_e == '0) ? '0 : tnew_e - TW'(1);
      sw_rt_m <= sw_e ? src_rt_e : '0;
      dest_w  <= dest_m;
    end
  end

  function automatic logic hit(input logic [RW-1:0] s, input logic [TW-1:0] tuse,
                               input logic [RW-1:0] dst, input logic [TW-1:0] tnew);
    return (s != '0) && (dst == s) && (tnew > tuse);
  endfunction

  // Nearest stage wins; M only once its result is actually ready
  function automatic logic [1:0] fwd_sel(input logic [RW-1:0] s, input logic [RW-1:0] dm,
                                         input logic [TW-1:0] tm, input logic [RW-1:0] dw);
    if (s == '0)                 return 2'd0;
    if ((s == dm) && (tm == '0)) return 2'd1;
    if (s == dw)                 return 2'd2;
    return 2'd0;
  endfunction

  always_comb begin
    stall = hit(src_rs_d, tuse_rs_d, dest_e, tnew_e) ||
            hit(src_rs_d, tuse_rs_d, dest_m, tnew_m) ||
            hit(src_rt_d, tuse_rt_d, dest_e, tnew_e) ||
            hit(src_rt_d, tuse_rt_d, dest_m, tnew_m);
    fwd_rs_d = fwd_sel(src_rs_d, dest_m, tnew_m, dest_w);
    fwd_rt_d = fwd_sel(src_rt_d, dest_m, tnew_m, dest_w);
    fwd_rs_e = fwd_sel(src_rs_e, dest_m, tnew_m, dest_w);
    fwd_rt_e = fwd_sel(src_rt_e, dest_m, tnew_m, dest_w);
    fwd_rt_m = (sw_rt_m != '0) && (sw_rt_m == dest_w);
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: short instruction pairs with hand-derived
// stall and forward-select expectations, checked each cycle #1 after driving ID.
module tb_hazard_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr_d;
  logic [3:0]  type_d;
  logic        stall;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic        fwd_rt_m;

  int n_cmp = 0;
  int n_bad = 0;

  hazard_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .instr_d  (instr_d),
    .type_d   (type_d),
    .stall    (stall),
    .fwd_rs_d (fwd_rs_d),
    .fwd_rt_d (fwd_rt_d),
    .fwd_rs_e (fwd_rs_e),
    .fwd_rt_e (fwd_rt_e),
    .fwd_rt_m (fwd_rt_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive the ID slot and let combinational outputs settle
  task automatic id(input logic [3:0] t, input logic [4:0] rs, input logic [4:0] rt,
                    input logic [4:0] rd);
    type_d  = t;
    instr_d = {6'd0, rs, rt, rd, 11'd0};
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    id(4'd0, 5'd0, 5'd0, 5'd0);
    tick(); tick(); tick();
  endtask

  initial begin
    rst_n = 1'b0;
    id(4'd4, 5'd1, 5'd4, 5'd0);

    // Reset held while lw/beq traffic flows
    tick();
    chk("rst_stall_lw", 2'(stall), 2'd0);
    id(4'd3, 5'd4, 5'd4, 5'd0);
    chk("rst_stall_beq", 2'(stall), 2'd0);
    chk("rst_fwd_rs_d", fwd_rs_d, 2'd0);
    tick();
    chk("rst_stall_beq2", 2'(stall), 2'd0);
    chk("rst_fwd_rs_e", fwd_rs_e, 2'd0);
    chk("rst_fwd_rt_e", fwd_rt_e, 2'd0);
    chk("rst_fwd_rt_m", 2'(fwd_rt_m), 2'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_stall", 2'(stall), 2'd0);
    chk("post_rst_fwd_rs_d", fwd_rs_d, 2'd0);
    flush();

    // addu $3,$1,$2 ; beq $3,$0
    id(4'd1, 5'd1, 5'd2, 5'd3);
    chk("a_addu_stall", 2'(stall), 2'd0);
    tick();
    id(4'd3, 5'd3, 5'd0, 5'd0);
    chk("a_beq_stall1", 2'(stall), 2'd1);
    tick();
    chk("a_beq_stall2", 2'(stall), 2'd0);
    chk("a_fwd_rs_d", fwd_rs_d, 2'd1);
    chk("a_fwd_rt_d", fwd_rt_d, 2'd0);
    flush();

    // lw $4,0($1) ; addu $5,$4,$4
    id(4'd4, 5'd1, 5'd4, 5'd0);
    chk("b_lw_stall", 2'(stall), 2'd0);
    tick();
    id(4'd1, 5'd4, 5'd4, 5'd5);
    chk("b_stall_c1", 2'(stall), 2'd1);
    tick();
    chk("b_stall_c2", 2'(stall), 2'd0);
    tick();
    id(4'd0, 5'd0, 5'd0, 5'd0);
    chk("b_fwd_rs_e", fwd_rs_e, 2'd2);
    chk("b_fwd_rt_e", fwd_rt_e, 2'd2);
    flush();

    // lw $4,0($1) ; jr $4
    id(4'd4, 5'd1, 5'd4, 5'd0);
    tick();
    id(4'd5, 5'd4, 5'd0, 5'd0);
    chk("c_stall_c1", 2'(stall), 2'd1);
    tick();
    chk("c_stall_c2", 2'(stall), 2'd1);
    chk("c_fwd_rs_d_c2", fwd_rs_d, 2'd0);
    tick();
    chk("c_stall_c3", 2'(stall), 2'd0);
    chk("c_fwd_rs_d", fwd_rs_d, 2'd2);
    flush();

    // lw $4,0($1) ; sw $4,0($2)
    id(4'd4, 5'd1, 5'd4, 5'd0);
    tick();
    id(4'd7, 5'd2, 5'd4, 5'd0);
    chk("d_stall_c1", 2'(stall), 2'd0);
    tick();
    id(4'd0, 5'd0, 5'd0, 5'd0);
    chk("d_stall_c2", 2'(stall), 2'd0);
    chk("d_fwd_rt_e", fwd_rt_e, 2'd0);
    chk("d_fwd_rt_m_c2", 2'(fwd_rt_m), 2'd0);
    tick();
    chk("d_fwd_rt_m", 2'(fwd_rt_m), 2'd1);
    flush();

    // ori $0,$1,5 ; addu $2,$0,$0
    id(4'd2, 5'd1, 5'd0, 5'd0);
    tick();
    id(4'd1, 5'd0, 5'd0, 5'd2);
    chk("e_stall", 2'(stall), 2'd0);
    chk("e_fwd_rs_d", fwd_rs_d, 2'd0);
    tick();
    id(4'd0, 5'd0, 5'd0, 5'd0);
    chk("e_fwd_rs_e", fwd_rs_e, 2'd0);
    chk("e_fwd_rt_e", fwd_rt_e, 2'd0);
    flush();

    // jal ; addu $2,$31,$0
    id(4'd6, 5'd0, 5'd0, 5'd0);
    tick();
    id(4'd1, 5'd31, 5'd0, 5'd2);
    chk("f_stall", 2'(stall), 2'd0);
    tick();
    id(4'd0, 5'd0, 5'd0, 5'd0);
    chk("f_fwd_rs_e", fwd_rs_e, 2'd1);
    chk("f_fwd_rt_e", fwd_rt_e, 2'd0);
    flush();

    // ori $3 twice, then addu $5,$3,$0: M beats W
    id(4'd2, 5'd1, 5'd3, 5'd0);
    tick();
    id(4'd2, 5'd2, 5'd3, 5'd0);
    tick();
    id(4'd1, 5'd3, 5'd0, 5'd5);
    chk("g_stall", 2'(stall), 2'd0);
    tick();
    id(4'd0, 5'd0, 5'd0, 5'd0);
    chk("g_fwd_rs_e_prio", fwd_rs_e, 2'd1);
    flush();

    // addu $3 ; beq $3,$3: both operands hazard, then both forward from M
    id(4'd1, 5'd1, 5'd2, 5'd3);
    tick();
    id(4'd3, 5'd3, 5'd3, 5'd0);
    chk("h_stall", 2'(stall), 2'd1);
    tick();
    chk("h_stall_clr", 2'(stall), 2'd0);
    chk("h_fwd_rs_d", fwd_rs_d, 2'd1);
    chk("h_fwd_rt_d", fwd_rt_d, 2'd1);
    flush();

    // Mid-program reset drops the in-flight lw
    id(4'd4, 5'd1, 5'd4, 5'd0);
    tick();
    id(4'd1, 5'd4, 5'd4, 5'd5);
    chk("i_stall_pre", 2'(stall), 2'd1);
    rst_n = 1'b0;
    #1;
    chk("i_stall_async", 2'(stall), 2'd0);
    #1 rst_n = 1'b1;
    tick();
    chk("i_stall_after", 2'(stall), 2'd0);
    tick();
    id(4'd0, 5'd0, 5'd0, 5'd0);
    chk("i_fwd_rs_e", fwd_rs_e, 2'd0);
    chk("i_fwd_rt_e", fwd_rt_e, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage MIPS core, sitting directly downstream of the ID-stage instruction decoder. Each cycle it takes the ID instruction and its 4-bit instruction-type class, tracks destination registers and result-ready times of instructions in E, M and W, and drives the stall and forwarding-mux selects. Hazards are resolved with the Tuse/Tnew method: stall only when forwarding cannot supply a value in time.

## Interface
- No parameters.
- `clk` in 1: core clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_d` in 32: instruction in ID; rs=[25:21], rt=[20:16], rd=[15:11].
- `type_d` in 4: class from the decoder. 0 = none, 1 = R-type, 2 = imm ALU (ori/lui), 3 = beq, 4 = lw, 5 = jr, 6 = jal, 7 = sw.
- `stall` out 1: hold PC and IF/ID, insert a bubble into ID/EX.
- `fwd_rs_d`, `fwd_rt_d` out 2: ID comparator operands (beq/jr). 0 = regfile, 1 = M result, 2 = W result.
- `fwd_rs_e`, `fwd_rt_e` out 2: ALU operands. 0 = ID/EX register, 1 = M result, 2 = W result.
- `fwd_rt_m` out 1: store data in M. 0 = EX/MEM register, 1 = W result.

## Operation
- Decode of the ID instruction, by type:
  - Type 1: reads rs and rt with tuse 1; writes rd; tnew 1.
  - Type 2: reads rs with tuse 1; writes rt; tnew 1.
  - Type 3: reads rs and rt with tuse 0; no write.
  - Type 4: reads rs with tuse 1; writes rt; tnew 2.
  - Type 5: reads rs with tuse 0; no write.
  - Type 6: no reads; writes register 31; tnew 1.
  - Type 7: reads rs with tuse 1 and rt with tuse 2; no write.
  - Type 0: no reads, no write.
- A destination of 0 is stored as "no write"; it never matches, stalls or forwards.
- Internal state, per stage E, M and W: `dest` (5 bits) and `tnew` (2 bits). W only needs `dest`.
- Every cycle:
  - E ← bubble (dest 0, tnew 0) if `stall`, else the ID fields.
  - M ← E, with tnew decremented, saturating at 0.
  - W ← M.dest.
- Stall (combinational): for any ID source s (non-zero) with tuse t, stall if stage X ∈ {E, M} has dest_X = s and tnew_X > t.
- Forwarding (combinational, nearest stage wins):
  - ID operands: 1 if M.dest = s and M.tnew = 0; else 2 if W.dest = s; else 0.
  - E operands use the rs/rt fields latched into E with the same rule. Sources not read by the E instruction give 0.
  - `fwd_rt_m` is 1 if the M instruction is sw and W.dest equals its rt (non-zero).
- The unit stores the type and register fields it needs internally. It does not depend on an external ID/EX register.

## Timing
- `stall` and all forward selects are combinational from `instr_d`, `type_d` and registered state. There is no added latency.
- Reset asserted (async): all stage state clears to bubble. `stall`, all `fwd_*` and `fwd_rt_m` go to 0 within the same cycle.
- Reset released mid-program: the pipeline restarts empty. Nothing is forwarded from pre-reset instructions.
- Stall lengths:
  - lw → dependent ALU or sw-address instruction: exactly 1 cycle.
  - lw → beq/jr: 2 cycles.
  - ALU/jal → beq/jr: 1 cycle.
  - lw → sw on rt: 0 cycles.
- Same register written by both M and W: M takes priority.
- Both rs and rt hazard in one cycle: a single `stall` is raised.
- Stalls repeat back-to-back until the condition clears; ID input is held by the upstream logic.

## Test plan
- Reset: hold `rst_n`=0 while applying lw/beq traffic. Outputs stay 0. After release, empty pipeline and no forwards.
- addu $3,$1,$2 then beq $3,$0: 1 stall cycle, then `fwd_rs_d`=1, `fwd_rt_d`=0.
- lw $4,0($1) then addu $5,$4,$4:
  - Cycle 1: `stall`=1.
  - Cycle 2: `stall`=0.
  - Cycle 3 (addu in E, lw in W): `fwd_rs_e`=`fwd_rt_e`=2.
- lw $4,0($1) then jr $4: `stall`=1 for 2 cycles, then `fwd_rs_d`=2.
- lw $4,0($1) then sw $4,0($2): `stall` never asserts. `fwd_rt_m`=1 when sw is in M.
- ori $0,$1,5 then addu $2,$0,$0: no stall, all forward selects 0. Also jal then addu $2,$31,$0 in the next slot: `fwd_rs_e`=1.
